// File: rtl/if_id_queue_if.sv
// if_id_queue_if
// Bundles the fetch-side and decode-side signals of the fetch/decode
// instruction queue.
//   Fetch side : inValid, inPC, inInstruction (to queue), full (from queue)
//   Decode side: outReady, flush (to queue),
//                outValid, outPC, outInstruction (from queue)
//   Debug      : count (from queue), the current occupancy
// master modport: the fetch/decode stages that drive the queue.
// slave modport : the queue itself.
interface if_id_queue_if #(
    parameter int WORD_LEN = 16,
    parameter int DEPTH    = 4
);
    logic                      inValid;
    logic [WORD_LEN-1:0]       inPC;
    logic [WORD_LEN-1:0]       inInstruction;
    logic                      full;
    logic                      outReady;
    logic                      outValid;
    logic [WORD_LEN-1:0]       outPC;
    logic [WORD_LEN-1:0]       outInstruction;
    logic                      flush;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output inValid, inPC, inInstruction, outReady, flush,
        input  full, outValid, outPC, outInstruction, count
    );

    modport slave (
        input  inValid, inPC, inInstruction, outReady, flush,
        output full, outValid, outPC, outInstruction, count
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue
// Instruction queue between fetch and decode. Buffers {PC, instruction}
// pairs in a DEPTH-entry circular buffer and presents the oldest entry
// show-ahead to decode. Fetch is frozen only when the queue is full; a
// branch/jump flush discards every queued entry.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (clears pointers, count, storage)
//   q   - if_id_queue_if slave: fetch push side, decode pop side, flush,
//         full/outValid status and the debug occupancy count
module if_id_queue #(
    parameter int WORD_LEN = 16,
    parameter int DEPTH    = 4
) (
    input  logic clk,
    input  logic rst,
    if_id_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_LEN-1:0] pcMem_q    [DEPTH];
    logic [WORD_LEN-1:0] instrMem_q [DEPTH];
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push, pop;

    // Status is decoded purely from the registered count, so full has no
    // path from outReady: a pop at count==DEPTH does not free room for a
    // push in that same cycle.
    assign q.full     = (count_q == CNT_W'(DEPTH));
    assign q.outValid = (count_q != '0);
    assign q.count    = count_q;

    // Show-ahead head entry, forced to zero when nothing is queued.
    assign q.outPC          = q.outValid ? pcMem_q[rdPtr_q]    : '0;
    assign q.outInstruction = q.outValid ? instrMem_q[rdPtr_q] : '0;

    // A flush wins over both handshakes; the push it collides with is on
    // the wrong path and must never be stored.
    assign push = q.inValid && !q.full && !q.flush;
    assign pop  = q.outValid && q.outReady && !q.flush;

    // Next-state for pointers and occupancy.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (q.flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and storage. Storage is cleared on reset so the
    // outputs never show stale data after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]    <= '0;
                instrMem_q[i] <= '0;
            end
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (push) begin
                pcMem_q[wrPtr_q]    <= q.inPC;
                instrMem_q[wrPtr_q] <= q.inInstruction;
            end
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue
// Directed self-checking bench for if_id_queue (WORD_LEN=16, DEPTH=4).
// Each instruction word is derived from its PC so every entry is unique.
module tb_if_id_queue;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    if_id_queue_if #(.WORD_LEN(16), .DEPTH(4)) qIf ();

    if_id_queue #(.WORD_LEN(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qIf)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mkInstr(input logic [15:0] pc);
        return pc ^ 16'hC35A;
    endfunction

    // Drive one cycle of inputs, let the rising edge happen, then settle.
    task automatic applyStimulus(input logic rstV, input logic inV,
                                 input logic [15:0] pc, input logic rdy,
                                 input logic fl);
        rst                   = rstV;
        qIf.inValid           = inV;
        qIf.inPC              = pc;
        qIf.inInstruction     = mkInstr(pc);
        qIf.outReady          = rdy;
        qIf.flush             = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Verify the head entry (or zero when empty) plus status flags.
    task automatic checkHead(input string tag, input logic valid,
                             input logic [15:0] pc, input logic [2:0] cnt,
                             input logic fullV);
        checkOutput({tag, ".count"}, 32'(qIf.count), 32'(cnt));
        checkOutput({tag, ".outValid"}, 32'(qIf.outValid), 32'(valid));
        checkOutput({tag, ".full"}, 32'(qIf.full), 32'(fullV));
        checkOutput({tag, ".outPC"}, 32'(qIf.outPC), valid ? 32'(pc) : 32'h0);
        checkOutput({tag, ".outInstr"}, 32'(qIf.outInstruction),
                    valid ? 32'(mkInstr(pc)) : 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset for two cycles.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checkHead("reset", 1'b0, 16'h0, 3'd0, 1'b0);

        // Fill with PCs 0,4,8,12; head stays at PC 0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(4 * i), 1'b0, 1'b0);
            checkHead($sformatf("fill%0d", i), 1'b1, 16'h0, 3'(i + 1), i == 3);
        end
        // Push while full is dropped.
        applyStimulus(1'b0, 1'b1, 16'd16, 1'b0, 1'b0);
        checkHead("pushFull", 1'b1, 16'h0, 3'd4, 1'b1);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d.outPC", i), 32'(qIf.outPC), 32'(4 * i));
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            checkOutput($sformatf("drain%0d.full", i), 32'(qIf.full), 32'h0);
        end
        checkHead("drained", 1'b0, 16'h0, 3'd0, 1'b0);

        // Pop while empty is ignored.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkHead("popEmpty", 1'b0, 16'h0, 3'd0, 1'b0);

        // Streaming with wrap: output lags input by one cycle, count holds at 1.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 16'(4 * k), 1'b1, 1'b0);
            checkHead($sformatf("stream%0d", k), 1'b1, 16'(4 * k), 3'd1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkHead("streamEnd", 1'b0, 16'h0, 3'd0, 1'b0);

        // Flush collision with three entries queued.
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0104, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0108, 1'b0, 1'b0);
        checkHead("preFlush", 1'b1, 16'h0100, 3'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0BAD, 1'b1, 1'b1);
        checkHead("flush", 1'b0, 16'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
        checkHead("postFlushPush", 1'b1, 16'h0200, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkHead("postFlushDrain", 1'b0, 16'h0, 3'd0, 1'b0);

        // Full with simultaneous pop and push: pop wins, push dropped.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(16'h0300 + 4 * i), 1'b0, 1'b0);
        end
        checkHead("full2", 1'b1, 16'h0300, 3'd4, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0310, 1'b1, 1'b0);
        checkHead("fullPopPush", 1'b1, 16'h0304, 3'd3, 1'b0);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("fullDrain%0d.outPC", i), 32'(qIf.outPC),
                        32'(16'h0300 + 4 * i));
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        end
        checkHead("fullDrained", 1'b0, 16'h0, 3'd0, 1'b0);

        // Reset mid-stream with two entries queued.
        applyStimulus(1'b0, 1'b1, 16'h0400, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0404, 1'b0, 1'b0);
        checkHead("preReset", 1'b1, 16'h0400, 3'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0408, 1'b1, 1'b0);
        checkHead("midReset", 1'b0, 16'h0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        checkHead("postReset", 1'b1, 16'h0040, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage. It buffers `{PC, instruction}` pairs produced by fetch and presents them in order to decode. It decouples decode freezes from fetch, so fetch stalls only when the queue is full. Any branch or jump redirect discards every queued entry.

## Interface
- `WORD_LEN`, 16: width of PC and instruction words.
- `DEPTH`, 4: number of entries; must be a power of two, minimum 2.
- `clk`  in  1: clock; every state change happens on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inValid`  in  1: fetch has a valid `{inPC, inInstruction}` this cycle.
- `inPC`  in  WORD_LEN: PC of the fetched instruction.
- `inInstruction`  in  WORD_LEN: fetched instruction word.
- `full`  out  1: queue cannot accept an entry; drives the fetch freeze input.
- `outReady`  in  1: decode consumes the head entry this cycle (decode is not frozen).
- `outValid`  out  1: head entry is valid.
- `outPC`  out  WORD_LEN: PC of the head entry.
- `outInstruction`  out  WORD_LEN: instruction of the head entry.
- `flush`  in  1: branch taken or jump enable; discards all entries.
- `count`  out  log2(DEPTH)+1: current occupancy, for debug and verification.

## Operation
- Circular buffer of DEPTH entries, each `{PC, instruction}`, with read pointer `rdPtr`, write pointer `wrPtr` (log2(DEPTH) bits, wrap modulo DEPTH) and occupancy counter `count`.
- Push happens when `inValid && !full`; the entry is written at `wrPtr`, then `wrPtr++`.
- Pop happens when `outValid && outReady`; then `rdPtr++`.
- Show-ahead output: `outPC` and `outInstruction` are the entry at `rdPtr`, combinationally from storage. They are 0 when the queue is empty.
- `outValid = (count != 0)`; `full = (count == DEPTH)`. Both are decoded from registered `count`, with no combinational path from inputs.
- Push and pop in the same cycle leave `count` unchanged and advance both pointers.
- A push while full is ignored: no pointer, count or storage change. Fetch is frozen by `full`, so this is a protocol error; the queue simply drops it.
- A pop while empty is ignored.
- `flush` has priority over push and pop in the same cycle:
  - `rdPtr`, `wrPtr` and `count` all go to 0.
  - The concurrent push is discarded, because that instruction is on the wrong path.
  - Storage contents are don't-care.
- `rst` has priority over everything and sets pointers and count to 0. Storage is cleared to 0 so outputs are deterministic.
- Counter arithmetic: `count` is log2(DEPTH)+1 bits wide and never exceeds DEPTH or goes below 0.

## Timing
- Reset values: `outValid=0`, `full=0`, `count=0`, `outPC=0`, `outInstruction=0`.
- Latency: an entry pushed at edge N is visible on `outPC`/`outInstruction` with `outValid=1` in the cycle after edge N. Minimum fetch-to-decode latency is one cycle. There is no bypass from input to output when empty.
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH-1.
  - At `count==DEPTH`, push is blocked even when a pop happens the same cycle. `full` is registered, so there is no ready-through path.
- `full` deasserts in the cycle after the first pop from a full queue.
- Flush at edge N gives `outValid=0` and `full=0` in the following cycle. A push at edge N+1 is accepted normally.
- Reset mid-operation, including while full or during a flush, returns the queue to the reset state at the next edge.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset, then fill: `rst=1` for 2 cycles, then push PCs 0, 4, 8, 12 with `outReady=0`.
  - Required: `count` goes 1, 2, 3, 4; `full=1` after the 4th edge.
  - A 5th push of PC 16 is ignored; `outPC` stays 0.
- Drain in order from full: `outReady=1`, `inValid=0`.
  - Required: `outPC` reads 0, 4, 8, 12 on successive cycles; `outValid=0` and `count=0` afterwards.
- Streaming with wrap: push and pop every cycle for 10 cycles, PCs 0 to 36 step 4.
  - Required: `count` holds at 1 and `outPC` lags `inPC` by exactly one cycle, in order across pointer wrap.
- Flush collision: with 3 entries queued, assert `flush`, `inValid`, `outReady` together.
  - Required: next cycle `count=0`, `outValid=0`, `full=0`; the flushed-cycle push never appears at the output.
- Full with simultaneous pop and push at `count=4`.
  - Required: pop accepted, push ignored; next cycle `count=3`, `full=0`, `outPC` equals the second-oldest entry.
- Reset mid-stream: `rst=1` while `count=2`.
  - Required: next cycle all outputs are at reset values, and a subsequent push of PC 0x0040 appears at the output one cycle later.
